// File: rtl/exe_div_sequencer_pkg.sv
// Shared definitions for the EXE-stage divider sequencer.
//  - div_state_e : sequencer FSM states
//  - QUO_* / REM_* : field positions inside the divider IP dout word
//  - pick_result : selects quotient or remainder from a dout word
package exe_div_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_e;

    localparam int QUO_MSB = 63;
    localparam int QUO_LSB = 32;
    localparam int REM_MSB = 31;
    localparam int REM_LSB = 0;

    // Returns remainder when use_rem is set, quotient otherwise.
    function automatic logic [31:0] pick_result(input logic [63:0] dout, input logic use_rem);
        logic [31:0] res;
        if (use_rem) begin
            res = dout[REM_MSB:REM_LSB];
        end else begin
            res = dout[QUO_MSB:QUO_LSB];
        end
        return res;
    endfunction

endpackage

// File: rtl/exe_div_sequencer.sv
// exe_div_sequencer: drives the signed/unsigned AXI-stream divider IPs for EXE.
// One div/mod op at a time: latch operands, hand them to the selected IP,
// wait for its dout, register quotient or remainder and hold it until EXE
// acknowledges. A flush at any point discards the op; an op already handed
// to an IP is drained (its dout swallowed) before returning to idle.
// Ports:
//  clk, reset                 clock, synchronous active-high reset
//  op_valid/op_unsigned/op_mod/op_src1/op_src2   operation request from EXE
//  flush, done_ack            EXE flush and result consume
//  busy, done_valid, done_result, err_timeout    status/result to EXE
//  s_tvalid/s_tready/s_dout_valid/s_dout         signed IP handshake
//  u_tvalid/u_tready/u_dout_valid/u_dout         unsigned IP handshake
//  dvd_data, dvs_data         registered dividend/divisor to both IPs
module exe_div_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_unsigned,
    input  logic        op_mod,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    input  logic        flush,
    input  logic        done_ack,
    output logic        busy,
    output logic        done_valid,
    output logic [31:0] done_result,
    output logic        err_timeout,
    output logic        s_tvalid,
    input  logic        s_tready,
    input  logic        s_dout_valid,
    input  logic [63:0] s_dout,
    output logic        u_tvalid,
    input  logic        u_tready,
    input  logic        u_dout_valid,
    input  logic [63:0] u_dout,
    output logic [31:0] dvd_data,
    output logic [31:0] dvs_data
);
    import exe_div_sequencer_pkg::*;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    div_state_e       state_r;
    div_state_e       state_s;
    logic             sel_unsigned_r;
    logic             mod_r;
    logic             flush_seen_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic             sel_tready_s;
    logic             sel_dout_valid_s;
    logic [63:0]      sel_dout_s;
    logic             sel_next_s;
    logic             latch_op_s;
    logic             latch_res_s;
    logic             timeout_hit_s;

    // Route the handshake of whichever IP the current op was latched for.
    always_comb begin
        if (sel_unsigned_r) begin
            sel_tready_s     = u_tready;
            sel_dout_valid_s = u_dout_valid;
            sel_dout_s       = u_dout;
        end else begin
            sel_tready_s     = s_tready;
            sel_dout_valid_s = s_dout_valid;
            sel_dout_s       = s_dout;
        end
    end

    // IP selection as it will be after this edge (a new op may be latching now).
    always_comb begin
        if (latch_op_s) begin
            sel_next_s = op_unsigned;
        end else begin
            sel_next_s = sel_unsigned_r;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s       = state_r;
        latch_op_s    = 1'b0;
        latch_res_s   = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    state_s    = ST_ISSUE;
                    latch_op_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // tvalid may not be withdrawn, so a flush only takes effect after accept.
                if (sel_tready_s) begin
                    if (flush || flush_seen_r) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (sel_dout_valid_s) begin
                    if (flush) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s     = ST_DONE;
                        latch_res_s = 1'b1;
                    end
                end else if (flush) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                    if (wait_cnt_r == CNT_LAST) begin
                        timeout_hit_s = 1'b1;
                    end else begin
                        timeout_hit_s = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (flush || done_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (sel_dout_valid_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and latched op attributes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            sel_unsigned_r <= 1'b0;
            mod_r          <= 1'b0;
        end else begin
            state_r <= state_s;
            if (latch_op_s) begin
                sel_unsigned_r <= op_unsigned;
                mod_r          <= op_mod;
            end
        end
    end

    // Remember a flush seen while the operand offer is still pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_seen_r <= 1'b0;
        end else if ((state_r == ST_ISSUE) && (state_s == ST_ISSUE)) begin
            flush_seen_r <= flush_seen_r | flush;
        end else begin
            flush_seen_r <= 1'b0;
        end
    end

    // Operand registers, stable for the whole offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_data <= 32'd0;
            dvs_data <= 32'd0;
        end else if (latch_op_s) begin
            dvd_data <= op_src1;
            dvs_data <= op_src2;
        end
    end

    // WAIT cycle counter; saturates so the timeout pulse fires only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_WAIT) && (state_s == ST_WAIT)) begin
            if (wait_cnt_r != CNT_MAX) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end
        end else begin
            wait_cnt_r <= CNT_ZERO;
        end
    end

    // Registered outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done_valid  <= 1'b0;
            done_result <= 32'd0;
            err_timeout <= 1'b0;
            s_tvalid    <= 1'b0;
            u_tvalid    <= 1'b0;
        end else begin
            busy        <= (state_s != ST_IDLE);
            done_valid  <= (state_s == ST_DONE);
            err_timeout <= timeout_hit_s;
            s_tvalid    <= (state_s == ST_ISSUE) && !sel_next_s;
            u_tvalid    <= (state_s == ST_ISSUE) && sel_next_s;
            if (latch_res_s) begin
                done_result <= pick_result(sel_dout_s, mod_r);
            end
        end
    end

endmodule

// File: tb/tb_exe_div_sequencer.sv
// Self-checking bench for exe_div_sequencer: emulates both divider IPs,
// keeps a transaction-level model of the expected outputs, compares on
// every falling edge, and pins the model with literal results.
module tb_exe_div_sequencer;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset, op_valid, op_unsigned, op_mod, flush, done_ack;
    logic [31:0] op_src1, op_src2;
    logic        busy, done_valid, err_timeout, s_tvalid, u_tvalid;
    logic [31:0] done_result, dvd_data, dvs_data;
    logic        s_tready = 1'b0, s_dout_valid = 1'b0;
    logic        u_tready = 1'b0, u_dout_valid = 1'b0;
    logic [63:0] s_dout = 64'd0, u_dout = 64'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_div_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_unsigned(op_unsigned),
        .op_mod(op_mod), .op_src1(op_src1), .op_src2(op_src2), .flush(flush),
        .done_ack(done_ack), .busy(busy), .done_valid(done_valid),
        .done_result(done_result), .err_timeout(err_timeout),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_dout_valid(s_dout_valid), .s_dout(s_dout),
        .u_tvalid(u_tvalid), .u_tready(u_tready), .u_dout_valid(u_dout_valid), .u_dout(u_dout),
        .dvd_data(dvd_data), .dvs_data(dvs_data)
    );

    // Plain-arithmetic division (truncating, remainder takes dividend sign).
    function automatic logic [31:0] ref_div(input logic uns, input logic mod,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (uns) return mod ? (a % b) : (a / b);
        return mod ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // ---------------- divider IP emulation ----------------
    int rdy_delay  = 0;
    int dout_delay = 1;
    int s_rcnt = 0, u_rcnt = 0, s_dcnt = 0, u_dcnt = 0;
    logic [63:0] s_pend = 64'd0, u_pend = 64'd0;

    always @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            s_pend = {ref_div(1'b0, 1'b0, dvd_data, dvs_data), ref_div(1'b0, 1'b1, dvd_data, dvs_data)};
            s_dcnt = dout_delay;
        end
        if (u_tvalid && u_tready) begin
            u_pend = {ref_div(1'b1, 1'b0, dvd_data, dvs_data), ref_div(1'b1, 1'b1, dvd_data, dvs_data)};
            u_dcnt = dout_delay;
        end
        #2;
        s_dout_valid = 1'b0;
        u_dout_valid = 1'b0;
        if (reset) begin
            s_tready = 1'b0; u_tready = 1'b0; s_dcnt = 0; u_dcnt = 0; s_rcnt = 0; u_rcnt = 0;
        end else begin
            if (s_dcnt > 0) begin
                s_dcnt--;
                if (s_dcnt == 0) begin s_dout_valid = 1'b1; s_dout = s_pend; end
            end
            if (u_dcnt > 0) begin
                u_dcnt--;
                if (u_dcnt == 0) begin u_dout_valid = 1'b1; u_dout = u_pend; end
            end
            if (s_tvalid && s_rcnt < rdy_delay) begin s_tready = 1'b0; s_rcnt++; end
            else if (s_tvalid) s_tready = 1'b1;
            else begin s_tready = 1'b0; s_rcnt = 0; end
            if (u_tvalid && u_rcnt < rdy_delay) begin u_tready = 1'b0; u_rcnt++; end
            else if (u_tvalid) u_tready = 1'b1;
            else begin u_tready = 1'b0; u_rcnt = 0; end
        end
    end

    // ---------------- transaction-level model ----------------
    // offer: operands being offered; fly: accepted, answer pending;
    // kill: the pending answer must be discarded; res_v: answer held for EXE.
    bit          m_offer = 1'b0, m_fly = 1'b0, m_kill = 1'b0, m_res_v = 1'b0;
    bit          m_uns = 1'b0, m_err = 1'b0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
    int          m_waited = 0;

    always @(posedge clk) begin
        bit rdy, dv;
        rdy   = m_uns ? u_tready : s_tready;
        dv    = m_uns ? u_dout_valid : s_dout_valid;
        m_err = 1'b0;
        if (reset) begin
            m_offer = 1'b0; m_fly = 1'b0; m_kill = 1'b0; m_res_v = 1'b0; m_uns = 1'b0;
        end else if (m_res_v) begin
            if (flush || done_ack) m_res_v = 1'b0;
        end else if (m_offer) begin
            if (flush) m_kill = 1'b1;
            if (rdy) begin m_offer = 1'b0; m_fly = 1'b1; m_waited = 0; end
        end else if (m_fly) begin
            if (dv) begin
                m_fly = 1'b0;
                if (!m_kill && !flush) m_res_v = 1'b1;
                m_kill = 1'b0;
            end else begin
                if (flush) m_kill = 1'b1;
                if (!m_kill) begin
                    m_waited++;
                    m_err = (m_waited == TIMEOUT);
                end
            end
        end else if (op_valid && !flush) begin
            m_offer = 1'b1;
            m_kill  = 1'b0;
            m_uns   = op_unsigned;
            m_a     = op_src1;
            m_b     = op_src2;
            m_res   = ref_div(op_unsigned, op_mod, op_src1, op_src2);
        end
    end

    // ---------------- checking / monitoring ----------------
    int cyc = 0;
    int s_tv_cnt = 0, u_tv_cnt = 0, dv_cnt = 0, err_cnt = 0;
    int last_dout_cyc = 0, done_rise_cyc = 0, busy_fall_cyc = 0, err_cyc = 0, acc_cyc = 0;
    logic prev_dv = 1'b0, prev_busy = 1'b0;
    logic [31:0] got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("busy", busy, m_offer | m_fly | m_res_v);
        chk("done_valid", done_valid, m_res_v);
        chk("s_tvalid", s_tvalid, m_offer & !m_uns);
        chk("u_tvalid", u_tvalid, m_offer & m_uns);
        chk("err_timeout", err_timeout, m_err);
        if (m_res_v) chk("done_result", done_result, m_res);
        if (m_offer) begin
            chk("dvd_data", dvd_data, m_a);
            chk("dvs_data", dvs_data, m_b);
        end
        if (s_tvalid) s_tv_cnt++;
        if (u_tvalid) u_tv_cnt++;
        if (done_valid) dv_cnt++;
        if (err_timeout) begin err_cnt++; err_cyc = cyc; end
        if (s_dout_valid || u_dout_valid) last_dout_cyc = cyc;
        if ((s_tvalid && s_tready) || (u_tvalid && u_tready)) acc_cyc = cyc;
        if (done_valid && !prev_dv) done_rise_cyc = cyc;
        if (!busy && prev_busy) busy_fall_cyc = cyc;
        prev_dv   = done_valid;
        prev_busy = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic uns, input logic mod, input logic [31:0] a, input logic [31:0] b,
                          input int rd, input int dd, input bit kill_done, output logic [31:0] res);
        int n;
        rdy_delay = rd;
        dout_delay = dd;
        op_valid = 1'b1; op_unsigned = uns; op_mod = mod; op_src1 = a; op_src2 = b;
        tick();
        n = 0;
        while (!done_valid && n < 300) begin tick(); n++; end
        chk("op_bound", (n < 300) ? 32'd1 : 32'd0, 32'd1);
        res = done_result;
        if (kill_done) flush = 1'b1; else done_ack = 1'b1;
        tick();
        flush = 1'b0; done_ack = 1'b0; op_valid = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        chk("idle_bound", (n < 300) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int snap_s, snap_u, snap_dv, snap_err;
        reset = 1'b1; op_valid = 1'b0; op_unsigned = 1'b0; op_mod = 1'b0;
        op_src1 = 32'd0; op_src2 = 32'd0; flush = 1'b0; done_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_result", done_result, 32'd0);
        chk("rst_tvalid", {s_tvalid, u_tvalid}, 2'b00);
        chk("rst_dvd", dvd_data, 32'd0);
        chk("rst_dvs", dvs_data, 32'd0);
        reset = 1'b0;
        tick();

        // signed 7/2 quotient, immediate tready, dout after 10 cycles
        run_op(1'b0, 1'b0, 32'd7, 32'd2, 0, 10, 1'b0, got);
        chk("s_7div2", got, 32'h0000_0003);
        chk("dv_latency", done_rise_cyc - last_dout_cyc, 32'd1);

        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 4, 1'b0, got);
        chk("s_m7mod2", got, 32'hFFFF_FFFF);
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1, 2, 1'b0, got);
        chk("s_m7div2", got, 32'hFFFF_FFFD);

        // unsigned ops never touch the signed IP
        snap_s = s_tv_cnt;
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 6, 1'b0, got);
        chk("u_quo", got, 32'h7FFF_FFFF);
        run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 2, 3, 1'b0, got);
        chk("u_rem", got, 32'h0000_0001);
        chk("s_tvalid_idle", s_tv_cnt - snap_s, 32'd0);

        // tready held low 3 cycles, flush during the offer
        snap_u = u_tv_cnt; snap_dv = dv_cnt;
        rdy_delay = 3; dout_delay = 3;
        op_valid = 1'b1; op_unsigned = 1'b1; op_mod = 1'b0; op_src1 = 32'd55; op_src2 = 32'd5;
        tick();
        flush = 1'b1; op_valid = 1'b0;
        tick();
        flush = 1'b0;
        wait_idle();
        chk("u_tvalid_len", u_tv_cnt - snap_u, 32'd4);
        chk("issue_flush_no_done", dv_cnt - snap_dv, 32'd0);

        // flush in WAIT, dout five cycles later, then a clean op
        snap_dv = dv_cnt;
        rdy_delay = 0; dout_delay = 7;
        op_valid = 1'b1; op_unsigned = 1'b1; op_mod = 1'b0; op_src1 = 32'd50; op_src2 = 32'd3;
        tick(); tick(); tick();
        flush = 1'b1; op_valid = 1'b0;
        tick();
        flush = 1'b0;
        wait_idle();
        chk("drain_busy_fall", busy_fall_cyc - last_dout_cyc, 32'd1);
        chk("wait_flush_no_done", dv_cnt - snap_dv, 32'd0);
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, 5, 1'b0, got);
        chk("u_100div7", got, 32'd14);

        // dout withheld past the timeout
        snap_err = err_cnt;
        run_op(1'b0, 1'b0, 32'd1000, 32'hFFFF_FFF7, 0, TIMEOUT + 5, 1'b0, got);
        chk("s_1000divm9", got, 32'hFFFF_FF91);
        chk("err_pulses", err_cnt - snap_err, 32'd1);
        chk("err_when", err_cyc - acc_cyc, 32'(TIMEOUT + 1));

        // flush while the result is held: no ack needed
        run_op(1'b0, 1'b1, 32'd9, 32'd4, 0, 2, 1'b1, got);
        chk("s_9mod4", got, 32'd1);
        chk("done_flush_idle", busy, 1'b0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
